// File: rtl/y86_pkg.sv
// Shared constants, FSM encoding and address helper for the Y86 prefetch buffer.
package y86_pkg;

    localparam logic [3:0]  MAX_INSTR_BYTES  = 4'd10;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'd32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return {addr[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/y86_prefetch_buffer_byte_ring.sv
// DEPTH x 8 circular byte store: up-to-8-byte masked write at the tail,
// MAX_INSTR_BYTES-wide little-endian read window at the head.
module byte_ring import y86_pkg::*; #(
    parameter int  DEPTH = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_ptr,
    input  logic [63:0]   wr_data,
    input  logic [7:0]    wr_be,
    input  logic [PW-1:0] rd_ptr,
    output logic [79:0]   rd_data
);

    logic [7:0] mem_r [DEPTH];

    // Lane i of the write word lands at wr_ptr+i, wrapping modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_ptr + PW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read window: byte k is the entry k places after the head.
    always_comb begin
        rd_data = 80'd0;
        for (int k = 0; k < int'(MAX_INSTR_BYTES); k++) begin
            rd_data[8*k +: 8] = mem_r[rd_ptr + PW'(k)];
        end
    end

endmodule

// File: rtl/y86_prefetch_buffer.sv
// Instruction prefetch buffer: fetches aligned 8-byte words into a byte queue
// and presents the next 10 bytes at buf_pc to the fetch stage.
module y86_prefetch_buffer import y86_pkg::*; #(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_valid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        consume,
    input  logic [3:0]  consume_len,
    output logic [63:0] buf_pc,
    output logic [79:0] buf_bytes,
    output logic [4:0]  buf_count,
    output logic        imem_error
);

    localparam int            PW        = $clog2(DEPTH);
    localparam int            CW        = PW + 1;
    localparam logic [CW-1:0] REQ_LIMIT = CW'(DEPTH - 8);

    fetch_state_t  state_r;
    logic          mem_req_r;
    logic [63:0]   mem_addr_r;
    logic [63:0]   buf_pc_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [2:0]    skip_r;
    logic          stale_r;
    logic          imem_error_r;

    logic          accept_s;
    logic          fill_s;
    logic          pop_s;
    logic [CW-1:0] fill_len_s;
    logic [CW-1:0] pop_len_s;
    logic [CW-1:0] count_next_s;
    logic [63:0]   wr_data_s;
    logic [7:0]    wr_be_s;

    // A redirect in the same cycle overrides both the response and the pop.
    always_comb begin
        accept_s     = (state_r == WAIT) && mem_valid && !stale_r && !redirect;
        fill_s       = accept_s && !mem_err;
        pop_s        = consume && (consume_len != 4'd0) && (consume_len <= MAX_INSTR_BYTES)
                       && (CW'(consume_len) <= count_r);
        fill_len_s   = fill_s ? CW'(4'd8 - {1'b0, skip_r}) : {CW{1'b0}};
        pop_len_s    = pop_s ? CW'(consume_len) : {CW{1'b0}};
        count_next_s = count_r - pop_len_s + fill_len_s;
        wr_data_s    = mem_rdata >> {skip_r, 3'b000};
        wr_be_s      = 8'hFF >> skip_r;
    end

    // Fetch FSM, fetch address, buffer PC and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= align_word(RESET_PC);
            buf_pc_r     <= RESET_PC;
            skip_r       <= RESET_PC[2:0];
            head_r       <= {PW{1'b0}};
            tail_r       <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            stale_r      <= 1'b0;
            imem_error_r <= 1'b0;
        end else if (redirect) begin
            mem_req_r    <= 1'b0;
            mem_addr_r   <= align_word(redirect_pc);
            buf_pc_r     <= redirect_pc;
            skip_r       <= redirect_pc[2:0];
            head_r       <= {PW{1'b0}};
            tail_r       <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            imem_error_r <= 1'b0;
            // A response landing this very cycle closes the old request, so nothing is left to discard.
            if ((state_r == WAIT) && !mem_valid) begin
                state_r <= WAIT;
                stale_r <= 1'b1;
            end else begin
                state_r <= IDLE;
                stale_r <= 1'b0;
            end
        end else begin
            mem_req_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!imem_error_r && (count_r <= REQ_LIMIT)) begin
                        mem_req_r <= 1'b1;
                        state_r   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_valid) begin
                        state_r <= IDLE;
                        stale_r <= 1'b0;
                        if (accept_s && mem_err) begin
                            imem_error_r <= 1'b1;
                        end
                        if (fill_s) begin
                            skip_r     <= 3'd0;
                            mem_addr_r <= mem_addr_r + 64'd8;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (pop_s) begin
                head_r   <= head_r + PW'(consume_len);
                buf_pc_r <= buf_pc_r + 64'(consume_len);
            end
            if (fill_s) begin
                tail_r <= tail_r + PW'(fill_len_s);
            end
            count_r <= count_next_s;
        end
    end

    byte_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fill_s),
        .wr_ptr  (tail_r),
        .wr_data (wr_data_s),
        .wr_be   (wr_be_s),
        .rd_ptr  (head_r),
        .rd_data (buf_bytes)
    );

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign buf_pc     = buf_pc_r;
    assign buf_count  = 5'(count_r);
    assign imem_error = imem_error_r;

endmodule

// File: tb/tb_y86_prefetch_buffer.sv
// Self-checking bench for y86_prefetch_buffer: byte-queue reference model,
// table-driven steady-state vectors, directed corner sequences, random traffic.
`timescale 1ns/1ps
module tb_y86_prefetch_buffer;
    import y86_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_valid;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        consume;
    logic [3:0]  consume_len;
    logic [63:0] buf_pc;
    logic [79:0] buf_bytes;
    logic [4:0]  buf_count;
    logic        imem_error;

    int n_checks = 0;
    int n_fail   = 0;

    y86_prefetch_buffer #(.RESET_PC(64'd32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .redirect(redirect), .redirect_pc(redirect_pc), .consume(consume),
        .consume_len(consume_len), .buf_pc(buf_pc), .buf_bytes(buf_bytes),
        .buf_count(buf_count), .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction memory image: two fixed words, everything else byte(a) = a[7:0] ^ 0xA5.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        logic [63:0] ai;
        w = 64'd0;
        if (a == 64'd32) begin
            w = 64'h0706050403020100;
        end else if (a == 64'h40) begin
            w = 64'h8877665544332211;
        end else begin
            for (int i = 0; i < 8; i++) begin
                ai = a + 64'(i);
                w[8*i +: 8] = ai[7:0] ^ 8'hA5;
            end
        end
        return w;
    endfunction

    // ---------------- memory responder ----------------
    int          lat      = 1;
    bit          lat_rand = 1'b0;
    bit          err_rand = 1'b0;
    int          err_arm  = 0;
    int          err_used = 0;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = 64'd0;

    initial begin
        mem_valid = 1'b0;
        mem_rdata = 64'd0;
        mem_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_err   = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (pend_cnt <= 1) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_word(pend_addr);
                    if (err_arm != err_used) begin
                        mem_err  = 1'b1;
                        err_used = err_arm;
                    end else if (err_rand && ($urandom_range(49, 0) == 0)) begin
                        mem_err = 1'b1;
                    end
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if (mem_req) begin
                pend      = 1'b1;
                pend_addr = mem_addr;
                pend_cnt  = lat_rand ? int'($urandom_range(4, 1)) : lat;
            end
        end
    end

    // ---------------- reference model: a byte queue starting at m_pc ----------------
    logic [7:0]  m_q[$];
    logic [63:0] m_pc    = 64'd32;
    logic [63:0] m_addr  = 64'd32;
    int          m_skip  = 0;
    bit          m_err   = 1'b0;
    bit          m_wait  = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_req   = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_pc = 64'd32; m_addr = 64'd32; m_skip = 0;
        m_err = 1'b0; m_wait = 1'b0; m_stale = 1'b0; m_req = 1'b0;
    endtask

    task automatic model_step();
        bit          resp;
        bit          issue;
        logic [63:0] w;
        resp = m_wait && mem_valid;
        if (redirect) begin
            m_q.delete();
            m_pc   = redirect_pc;
            m_addr = {redirect_pc[63:3], 3'b000};
            m_skip = int'(redirect_pc[2:0]);
            m_err  = 1'b0;
            m_req  = 1'b0;
            if (m_wait && !mem_valid) m_stale = 1'b1;
            else begin m_wait = 1'b0; m_stale = 1'b0; end
        end else begin
            issue = !m_wait && !m_err && ((DEPTH - m_q.size()) >= 8);
            if (consume && consume_len >= 4'd1 && consume_len <= 4'd10 && int'(consume_len) <= m_q.size()) begin
                for (int i = 0; i < int'(consume_len); i++) void'(m_q.pop_front());
                m_pc = m_pc + 64'(consume_len);
            end
            if (resp) begin
                if (!m_stale) begin
                    if (mem_err) begin
                        m_err = 1'b1;
                    end else begin
                        w = mem_word(m_addr);
                        for (int i = m_skip; i < 8; i++) m_q.push_back(w[8*i +: 8]);
                        m_addr = m_addr + 64'd8;
                        m_skip = 0;
                    end
                end
                m_wait = 1'b0;
                m_stale = 1'b0;
            end
            m_req = issue;
            if (issue) m_wait = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every cycle out of reset: all outputs against the model, only valid window bytes.
    initial begin
        logic [79:0] exp_w;
        logic [79:0] mask;
        int          n;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_w = 80'd0;
                mask  = 80'd0;
                n = (m_q.size() < 10) ? m_q.size() : 10;
                for (int k = 0; k < n; k++) begin
                    exp_w[8*k +: 8] = m_q[k];
                    mask[8*k +: 8]  = 8'hFF;
                end
                chk("model_count", 80'(buf_count), 80'(m_q.size()));
                chk("model_pc", 80'(buf_pc), 80'(m_pc));
                chk("model_imem_error", 80'(imem_error), 80'(m_err));
                chk("model_mem_req", 80'(mem_req), 80'(m_req));
                chk("model_mem_addr", 80'(mem_addr), 80'(m_addr));
                chk("model_window", buf_bytes & mask, exp_w);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        redirect = 1'b1; redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic pulse_consume(input logic [3:0] len);
        consume = 1'b1; consume_len = len;
        @(negedge clk);
        consume = 1'b0;
    endtask

    task automatic wait_req(input int bound, input string name);
        for (int i = 0; i < bound && !mem_req; i++) @(negedge clk);
        chk(name, 80'(mem_req), 80'd1);
    endtask

    task automatic wait_valid(input int bound, input string name);
        for (int i = 0; i < bound && !mem_valid; i++) @(negedge clk);
        chk(name, 80'(mem_valid), 80'd1);
    endtask

    task automatic wait_nonempty(input int bound, input string name);
        for (int i = 0; i < bound && buf_count == 5'd0; i++) @(negedge clk);
        chk(name, 80'(buf_count != 5'd0), 80'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_mem_req"}, 80'(mem_req), 80'd0);
        chk({tag, "_mem_addr"}, 80'(mem_addr), 80'd32);
        chk({tag, "_buf_pc"}, 80'(buf_pc), 80'd32);
        chk({tag, "_buf_count"}, 80'(buf_count), 80'd0);
        chk({tag, "_buf_bytes"}, buf_bytes, 80'd0);
        chk({tag, "_imem_error"}, 80'(imem_error), 80'd0);
    endtask

    typedef struct {
        logic        redirect;
        logic [63:0] pc;
        logic [3:0]  len;
        logic [4:0]  exp_count;
        logic [63:0] exp_pc;
        logic [7:0]  exp_b0;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 64'd0,   4'd11, 5'd16, 64'h20, 8'h00};
        vecs[1] = '{1'b0, 64'd0,   4'd0,  5'd16, 64'h20, 8'h00};
        vecs[2] = '{1'b0, 64'd0,   4'd3,  5'd13, 64'h23, 8'h03};
        vecs[3] = '{1'b0, 64'd0,   4'd10, 5'd11, 64'h2D, 8'h88};
        vecs[4] = '{1'b1, 64'h43,  4'd0,  5'd13, 64'h43, 8'h44};
        vecs[5] = '{1'b0, 64'd0,   4'd12, 5'd13, 64'h43, 8'h44};
        vecs[6] = '{1'b0, 64'd0,   4'd10, 5'd11, 64'h4D, 8'hE8};
        vecs[7] = '{1'b0, 64'd0,   4'd10, 5'd9,  64'h57, 8'hF2};
        vecs[8] = '{1'b0, 64'd0,   4'd10, 5'd9,  64'h57, 8'hF2};
        vecs[9] = '{1'b0, 64'd0,   4'd9,  5'd16, 64'h60, 8'hC5};

        redirect = 1'b0; redirect_pc = 64'd0; consume = 1'b0; consume_len = 4'd0;
        tick(2);
        chk_reset_values("reset");
        rst_n = 1'b1;

        // First fill from RESET_PC, second request, then the third is withheld.
        wait_nonempty(6, "first_fill_timeout");
        chk("first_count", 80'(buf_count), 80'd8);
        chk("first_byte0", 80'(buf_bytes[7:0]), 80'h00);
        chk("first_pc", 80'(buf_pc), 80'd32);
        wait_req(6, "second_req_timeout");
        chk("second_req_addr", 80'(mem_addr), 80'd40);
        tick(4);
        chk("full_count", 80'(buf_count), 80'd16);
        for (int i = 0; i < 6; i++) begin
            chk("third_req_withheld", 80'(mem_req), 80'd0);
            tick(1);
        end

        // Steady-state vectors: one pulse, let fills settle, compare.
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].redirect) pulse_redirect(vecs[v].pc);
            else pulse_consume(vecs[v].len);
            tick(10);
            chk($sformatf("vec%0d_count", v), 80'(buf_count), 80'(vecs[v].exp_count));
            chk($sformatf("vec%0d_pc", v), 80'(buf_pc), 80'(vecs[v].exp_pc));
            chk($sformatf("vec%0d_byte0", v), 80'(buf_bytes[7:0]), 80'(vecs[v].exp_b0));
        end

        // Redirect to an unaligned PC: first partial word.
        pulse_redirect(64'h43);
        wait_nonempty(6, "redirect_fill_timeout");
        chk("redirect_count", 80'(buf_count), 80'd5);
        chk("redirect_bytes", 80'(buf_bytes[39:0]), 80'h8877665544);
        chk("redirect_pc", 80'(buf_pc), 80'h43);
        tick(8);

        // Redirect while a slow response is outstanding: it must be discarded.
        lat = 5;
        pulse_redirect(64'h200);
        wait_req(4, "stale_first_req_timeout");
        pulse_redirect(64'h101);
        wait_valid(8, "stale_resp_timeout");
        tick(1);
        chk("stale_discarded", 80'(buf_count), 80'd0);
        wait_req(4, "post_stale_req_timeout");
        chk("post_stale_addr", 80'(mem_addr), 80'h100);
        wait_nonempty(10, "post_stale_fill_timeout");
        chk("post_stale_count", 80'(buf_count), 80'd7);
        chk("post_stale_byte0", 80'(buf_bytes[7:0]), 80'hA4);
        tick(20);

        // Error response: sticky flag, no bytes, no requests until redirect.
        lat = 1;
        err_arm++;
        pulse_redirect(64'h300);
        for (int i = 0; i < 6 && !imem_error; i++) tick(1);
        chk("err_flag", 80'(imem_error), 80'd1);
        chk("err_count", 80'(buf_count), 80'd0);
        for (int i = 0; i < 6; i++) begin
            chk("err_no_req", 80'(mem_req), 80'd0);
            tick(1);
        end
        pulse_redirect(64'h308);
        chk("err_cleared", 80'(imem_error), 80'd0);
        wait_nonempty(6, "err_resume_timeout");
        chk("err_resume_count", 80'(buf_count), 80'd8);
        chk("err_resume_byte0", 80'(buf_bytes[7:0]), 80'hAD);
        tick(8);

        // Reset in the middle of an outstanding request.
        lat = 5;
        pulse_redirect(64'h500);
        wait_req(4, "midreset_req_timeout");
        rst_n = 1'b0;
        tick(1);
        chk_reset_values("midreset");
        rst_n = 1'b1;
        lat = 1;
        wait_nonempty(12, "midreset_fill_timeout");
        chk("midreset_count", 80'(buf_count), 80'd8);
        chk("midreset_byte0", 80'(buf_bytes[7:0]), 80'h00);
        chk("midreset_pc", 80'(buf_pc), 80'd32);

        // Random traffic against the model.
        lat_rand = 1'b1;
        err_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            redirect    = ($urandom_range(99, 0) < 3);
            redirect_pc = 64'($urandom_range(1023, 0));
            consume     = $urandom_range(1, 0) == 1;
            consume_len = 4'($urandom_range(12, 0));
            tick(1);
        end
        redirect = 1'b0; consume = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/y86_prefetch_buffer.md
Name: y86_prefetch_buffer

Overview:
- Instruction prefetch buffer directly upstream of the Y86 fetch stage.
- Reads instruction memory as 8-byte aligned words and holds a byte queue starting at the current PC.
- Presents the next 10 bytes, enough for the longest Y86 instruction, little-endian and byte-aligned to fetch.
- Fetch pops the bytes it decoded; a PC update that is not sequential (jump, call, ret) flushes and refills the queue.

Parameters:
- RESET_PC, 64'd32: PC the buffer starts fetching from after reset.
- DEPTH, 16: queue capacity in bytes. Must be a power of two and at least 16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- mem_req  out  1  single-cycle read request pulse.
- mem_addr  out  64  word address; bits [2:0] are always 0.
- mem_valid  in  1  read response strobe.
- mem_rdata  in  64  response word; byte i = bits [8i+7:8i].
- mem_err  in  1  response error, sampled with mem_valid.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  64  new PC.
- consume  in  1  pop strobe.
- consume_len  in  4  bytes to pop, 1..10.
- buf_pc  out  64  PC of buf_bytes byte 0.
- buf_bytes  out  80  next 10 queued bytes; byte 0 is in [7:0].
- buf_count  out  5  valid bytes queued, 0..DEPTH.
- imem_error  out  1  sticky fetch error.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=RESET_PC&~7.
  - buf_pc=RESET_PC, buf_count=0, buf_bytes=0, imem_error=0.
  - head/tail pointers 0, skip=RESET_PC[2:0], state IDLE, stale=0.
- Reset asserted mid-transaction: all state is cleared immediately. A response arriving after reset release is accepted as a fresh one only if a request was issued after release; otherwise it is ignored.
- FSM states:
  - IDLE: if !imem_error and free space (DEPTH-buf_count) >= 8, pulse mem_req for one cycle with mem_addr, then go to WAIT. At most one request is outstanding.
  - WAIT: on mem_valid, return to IDLE. If stale=0, do a fill.
  - A request may be issued in the cycle after the response at the earliest.
- Fill:
  - Write bytes skip..7 of mem_rdata at the tail; tail += 8-skip (mod DEPTH); count += 8-skip.
  - Then set skip=0 and mem_addr += 8.
  - If mem_err=1, write no bytes and set imem_error=1.
  - imem_error is sticky until redirect and blocks new requests.
- Consume:
  - If consume=1 and consume_len<=buf_count: head += len (mod DEPTH), buf_pc += len, count -= len.
  - If consume_len > buf_count, or consume_len=0: ignore (no state change).
- Consume and fill in the same cycle: both apply; count_next = count - len + fill.
- Redirect has priority over consume and fill in the same cycle:
  - head=tail=0, count=0, buf_pc=redirect_pc.
  - mem_addr=redirect_pc&~7, skip=redirect_pc[2:0], imem_error=0.
  - If in WAIT, set stale=1: the outstanding response is discarded, and the new request is issued after it.
  - stale clears on that response.
- Wrap-around: pointers wrap modulo DEPTH. buf_bytes byte k = queue[(head+k) mod DEPTH].
- Bytes beyond buf_count are don't-care; the bench must not check them.
- Latency: with a 1-cycle memory, the first bytes are visible 2 cycles after reset release or after redirect (request cycle plus response cycle).
- Outputs are combinational from registers only; there is no combinational path from any input to any output.

Decomposition:
- Shared package y86_pkg holds:
  - instruction length constant MAX_INSTR_BYTES=10;
  - RESET_PC default;
  - FSM state enum {IDLE, WAIT}.
- Sub-module byte_ring (DEPTH x 8 register file) provides:
  - a write port of up to 8 bytes at tail with a byte enable;
  - a 10-byte read window at head.

Test Plan:
- Reset release, 1-cycle memory returning word 0x0706050403020100 at addr 32, consume idle:
  - buf_pc=32, buf_count=8, buf_bytes[7:0]=0x00.
  - A second request to addr 40 is issued; the third request is withheld because free space < 8.
- Redirect to PC 0x43 (word 0x40 = 0x8877665544332211):
  - After 2 cycles buf_count=5, buf_bytes[7:0]=0x44, buf_pc=0x43.
- Consume len 10 against count 16 alongside a concurrent fill of 8 bytes:
  - count becomes 14 and buf_pc advances by 10.
  - Repeat until the head pointer wraps past 15; window bytes stay in memory order.
- Redirect issued while WAIT with a 5-cycle memory latency:
  - The old response is discarded (count stays 0).
  - The next mem_addr equals the new aligned PC.
- mem_err=1 on a response:
  - imem_error=1, no bytes are added and mem_req stays 0.
  - A following redirect clears imem_error and fetching resumes.
- consume_len=11 or consume_len > buf_count: no change to buf_pc or buf_count.
